// File: rtl/uart_apb_pkg.sv
// Shared definitions for the APB-side UART host: register map, STATUS bits,
// host state encoding and CTRL2 packing. CFG3 exists only with UART_APB_HOST_FRAC_EN.
package uart_apb_pkg;

  localparam logic [4:0] ADDR_TX     = 5'h00;
  localparam logic [4:0] ADDR_RX     = 5'h04;
  localparam logic [4:0] ADDR_CTRL1  = 5'h08;
  localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
  localparam logic [4:0] ADDR_STATUS = 5'h10;
  localparam logic [4:0] ADDR_CTRL3  = 5'h14;

  localparam int STAT_TXRDY    = 0;
  localparam int STAT_RXRDY    = 1;
  localparam int STAT_PARITY   = 2;
  localparam int STAT_OVERFLOW = 3;
  localparam int STAT_FRAMING  = 4;

  typedef enum logic [2:0] {
    S_CFG1,
    S_CFG2,
`ifdef UART_APB_HOST_FRAC_EN
    S_CFG3,
`endif
    S_POLL,
    S_GAP,
    S_RXRD,
    S_TXWR
  } state_e;

  function automatic logic [7:0] ctrl2_pack(input logic [4:0] baud_hi, input logic odd,
                                            input logic par_en, input logic bit8);
    return {baud_hi, odd, par_en, bit8};
  endfunction

endpackage

// File: rtl/uart_apb_host.sv
// APB3 initiator driving a UART slave: programs baud/frame registers, then polls STATUS
// and moves bytes between tx/rx streams and the data registers. Optional: UART_APB_HOST_FRAC_EN.
module uart_apb_host
  import uart_apb_pkg::*;
#(
  parameter logic [12:0] BAUD_VALUE    = 13'd0,
  parameter logic        BIT8          = 1'b1,
  parameter logic        PARITY_EN     = 1'b0,
  parameter logic        ODD_N_EVEN    = 1'b0,
`ifdef UART_APB_HOST_FRAC_EN
  parameter logic [2:0]  BAUD_FRACTION = 3'd0,
`endif
  parameter int unsigned POLL_GAP      = 0
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  output logic [4:0] PADDR,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic       PSLVERR,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       cfg_done,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow,
  output logic       bus_err,
  input  logic       err_clr
);

  state_e     state_q, state_d;
  logic       psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [4:0] paddr_q, paddr_d;
  logic [7:0] pwdata_q, pwdata_d, rx_data_q, rx_data_d, gap_q, gap_d;
  logic       rx_valid_q, rx_valid_d, cfg_done_q, cfg_done_d;
  logic       par_q, par_d, ovf_q, ovf_d, frm_q, frm_d, berr_q, berr_d;
  logic       start, rx_take, tx_take;

  // RX wins when both directions have work; a held rx byte blocks further reads.
  assign rx_take = PRDATA[STAT_RXRDY] & ~rx_valid_q;
  assign tx_take = PRDATA[STAT_TXRDY] & tx_valid & ~rx_take & cfg_done_q;

  always_comb begin
    state_d    = state_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    gap_d      = gap_q;
    cfg_done_d = cfg_done_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q & ~rx_ready;
    par_d      = par_q & ~err_clr;
    ovf_d      = ovf_q & ~err_clr;
    frm_d      = frm_q & ~err_clr;
    berr_d     = berr_q & ~err_clr;
    tx_ready   = 1'b0;
    start      = 1'b0;

    if (state_q == S_GAP) begin
      if (gap_q == 8'd0) begin
        state_d = S_POLL;
        start   = 1'b1;
      end else begin
        gap_d = gap_q - 8'd1;
      end
    end else if (!psel_q) begin
      start = 1'b1;
    end else if (!penable_q) begin
      penable_d = 1'b1;
    end else if (PREADY) begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
      start     = 1'b1;
      if (PSLVERR) berr_d = 1'b1;
      unique case (state_q)
        S_CFG1: state_d = S_CFG2;
`ifdef UART_APB_HOST_FRAC_EN
        S_CFG2: state_d = S_CFG3;
        S_CFG3: begin state_d = S_POLL; cfg_done_d = 1'b1; end
`else
        S_CFG2: begin state_d = S_POLL; cfg_done_d = 1'b1; end
`endif
        S_POLL: begin
          if (PRDATA[STAT_PARITY])   par_d = 1'b1;
          if (PRDATA[STAT_OVERFLOW]) ovf_d = 1'b1;
          if (PRDATA[STAT_FRAMING])  frm_d = 1'b1;
          if (rx_take) begin
            state_d = S_RXRD;
          end else if (tx_take) begin
            tx_ready = 1'b1;
            state_d  = S_TXWR;
          end else if (POLL_GAP != 0) begin
            state_d = S_GAP;
            start   = 1'b0;
            gap_d   = 8'(POLL_GAP - 1);
          end
        end
        S_RXRD: begin
          rx_data_d  = PRDATA;
          rx_valid_d = 1'b1;
          state_d    = S_POLL;
        end
        default: state_d = S_POLL;
      endcase
    end

    // SETUP phase of the transfer belonging to state_d (back-to-back when completing).
    if (start) begin
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = 1'b1;
      pwdata_d  = 8'h00;
      case (state_d)
        S_CFG1: begin paddr_d = ADDR_CTRL1; pwdata_d = BAUD_VALUE[7:0]; end
        S_CFG2: begin
          paddr_d  = ADDR_CTRL2;
          pwdata_d = ctrl2_pack(BAUD_VALUE[12:8], ODD_N_EVEN, PARITY_EN, BIT8);
        end
`ifdef UART_APB_HOST_FRAC_EN
        S_CFG3: begin paddr_d = ADDR_CTRL3; pwdata_d = {5'b0, BAUD_FRACTION}; end
`endif
        S_POLL: begin paddr_d = ADDR_STATUS; pwrite_d = 1'b0; end
        S_RXRD: begin paddr_d = ADDR_RX; pwrite_d = 1'b0; end
        default: begin paddr_d = ADDR_TX; pwdata_d = tx_data; end
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q    <= S_CFG1;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= 5'd0;
      pwdata_q   <= 8'd0;
      gap_q      <= 8'd0;
      cfg_done_q <= 1'b0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      par_q      <= 1'b0;
      ovf_q      <= 1'b0;
      frm_q      <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      gap_q      <= gap_d;
      cfg_done_q <= cfg_done_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      par_q      <= par_d;
      ovf_q      <= ovf_d;
      frm_q      <= frm_d;
      berr_q     <= berr_d;
    end
  end

  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign cfg_done    = cfg_done_q;
  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;
  assign parity_err  = par_q;
  assign overflow    = ovf_q;
  assign framing_err = frm_q;
  assign bus_err     = berr_q;

endmodule

// File: tb/tb_uart_apb_host.sv
// Directed bench for uart_apb_host: a tiny APB slave answers STATUS/RX reads; a vector
// table drives poll scenarios, hand sequences cover wait states, errors and reset.
module tb_uart_apb_host;

  logic       PCLK, PRESETN;
  logic [4:0] PADDR;
  logic       PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [7:0] PWDATA, PRDATA;
  logic       tx_valid, tx_ready, rx_valid, rx_ready, cfg_done;
  logic [7:0] tx_data, rx_data;
  logic       parity_err, framing_err, overflow, bus_err, err_clr;

  logic [7:0] status_r, rxd_r;
  logic       pready_r, pslverr_r;
  int         n_chk, n_fail;

  assign PRDATA  = (PADDR == 5'h10) ? status_r : (PADDR == 5'h04) ? rxd_r : 8'h00;
  assign PREADY  = pready_r;
  assign PSLVERR = pslverr_r;

  uart_apb_host #(
    .BAUD_VALUE(13'h1A5), .BIT8(1'b1), .PARITY_EN(1'b1), .ODD_N_EVEN(1'b0), .POLL_GAP(3)
  ) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .cfg_done(cfg_done),
    .parity_err(parity_err), .framing_err(framing_err), .overflow(overflow),
    .bus_err(bus_err), .err_clr(err_clr)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [7:0] status; logic txv; logic [7:0] txd; logic rxr; logic [7:0] rxd;
    int exp_txr; logic [4:0] exp_addr; logic exp_wr; logic [7:0] exp_wd; int exp_idle;
    logic exp_rxv; logic [7:0] exp_rxdat; logic [2:0] exp_flags;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs to the next completed transfer; counts PSEL-low cycles and tx_ready pulses.
  task automatic next_xfer(output logic [4:0] a, output logic w, output logic [7:0] d,
                           output int idle, output int txr);
    idle = 0; txr = 0; a = 5'h1F; w = 1'b0; d = 8'h00;
    for (int i = 0; i < 100; i++) begin
      @(negedge PCLK);
      if (tx_ready) txr++;
      if (!PSEL) idle++;
      if (PSEL && PENABLE && PREADY) begin
        a = PADDR; w = PWRITE; d = PWDATA;
        if (tx_ready) begin
          @(posedge PCLK); #1;
          tx_valid = 1'b0;
        end
        return;
      end
    end
    n_chk++; n_fail++;
    $display("FAIL xfer_timeout: no APB completion within 100 cycles");
  endtask

  // Configuration after reset release: CTRL1=0xA5, CTRL2=0x0B, cfg_done 4 cycles after SETUP.
  task automatic cfg_seq(input string tag);
    int i;
    for (i = 0; i < 10; i++) begin
      @(negedge PCLK);
      if (PSEL) break;
    end
    check({tag, " cfg_start"}, 32'(i < 10), 32'd1);
    check({tag, " cfg1_setup"}, {PENABLE, PWRITE, PADDR, PWDATA}, {1'b0, 1'b1, 5'h08, 8'hA5});
    check({tag, " cfg_done_c0"}, cfg_done, 1'b0);
    @(negedge PCLK);
    check({tag, " cfg1_access"}, {PSEL, PENABLE}, 2'b11);
    @(negedge PCLK);
    check({tag, " cfg2_setup"}, {PSEL, PENABLE, PWRITE, PADDR, PWDATA},
          {1'b1, 1'b0, 1'b1, 5'h0C, 8'h0B});
    @(negedge PCLK);
    check({tag, " cfg_done_c3"}, cfg_done, 1'b0);
    @(negedge PCLK);
    check({tag, " cfg_done_c4"}, cfg_done, 1'b1);
    check({tag, " poll_setup"}, {PSEL, PENABLE, PWRITE, PADDR}, {1'b1, 1'b0, 1'b0, 5'h10});
  endtask

  initial begin
    logic [4:0] a;
    logic       w;
    logic [7:0] d;
    int         idle, txr;
    bit         found;
    vec_t       v;

    n_chk = 0; n_fail = 0;
    //           status txv  txd    rxr   rxd    txr addr   wr    wd     idle rxv   rxdat  flags
    vecs[0] = '{8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 0, 5'h10, 1'b0, 8'h00, 3, 1'b0, 8'h00, 3'b000};
    vecs[1] = '{8'h01, 1'b1, 8'h55, 1'b1, 8'h00, 1, 5'h00, 1'b1, 8'h55, 0, 1'b0, 8'h00, 3'b000};
    vecs[2] = '{8'h03, 1'b1, 8'hA7, 1'b0, 8'h3C, 0, 5'h04, 1'b0, 8'h00, 0, 1'b1, 8'h3C, 3'b000};
    vecs[3] = '{8'h03, 1'b1, 8'hA7, 1'b0, 8'h3C, 1, 5'h00, 1'b1, 8'hA7, 0, 1'b1, 8'h3C, 3'b000};
    vecs[4] = '{8'h02, 1'b0, 8'h00, 1'b0, 8'h3C, 0, 5'h10, 1'b0, 8'h00, 3, 1'b1, 8'h3C, 3'b000};
    vecs[5] = '{8'h02, 1'b0, 8'h00, 1'b1, 8'hC3, 0, 5'h04, 1'b0, 8'h00, 0, 1'b1, 8'hC3, 3'b000};
    vecs[6] = '{8'h1C, 1'b0, 8'h00, 1'b0, 8'hC3, 0, 5'h10, 1'b0, 8'h00, 3, 1'b1, 8'hC3, 3'b111};

    PRESETN = 1'b0; status_r = 8'h00; rxd_r = 8'h00; pready_r = 1'b1; pslverr_r = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge PCLK);
    check("reset_apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 16'h0);
    check("reset_misc", {tx_ready, rx_valid, rx_data, cfg_done}, 11'h0);
    check("reset_flags", {parity_err, framing_err, overflow, bus_err}, 4'h0);
    PRESETN = 1'b1;
    cfg_seq("boot");

    for (int r = 0; r < 7; r++) begin
      v = vecs[r];
      status_r = v.status; tx_valid = v.txv; tx_data = v.txd; rx_ready = v.rxr; rxd_r = v.rxd;
      next_xfer(a, w, d, idle, txr);
      check($sformatf("r%0d poll", r), {w, a}, {1'b0, 5'h10});
      check($sformatf("r%0d tx_ready", r), txr, v.exp_txr);
      next_xfer(a, w, d, idle, txr);
      check($sformatf("r%0d next_xfer", r), {w, a}, {v.exp_wr, v.exp_addr});
      if (v.exp_wr) check($sformatf("r%0d pwdata", r), d, v.exp_wd);
      check($sformatf("r%0d idle", r), idle, v.exp_idle);
      @(negedge PCLK);
      check($sformatf("r%0d rx_valid", r), rx_valid, v.exp_rxv);
      if (v.exp_rxv) check($sformatf("r%0d rx_data", r), rx_data, v.exp_rxdat);
      check($sformatf("r%0d flags", r), {framing_err, overflow, parity_err}, v.exp_flags);
      check($sformatf("r%0d bus_err", r), bus_err, 1'b0);
    end

    // err_clr during GAP clears every sticky flag.
    status_r = 8'h00; err_clr = 1'b1;
    @(negedge PCLK);
    err_clr = 1'b0;
    check("err_clr", {framing_err, overflow, parity_err, bus_err}, 4'h0);

    // Three PREADY-low ACCESS cycles, then PSLVERR completion with err_clr (set wins).
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge PCLK);
      if (PSEL && !PENABLE) found = 1'b1;
    end
    check("wait_setup_found", found, 1'b1);
    pready_r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      check($sformatf("wait_stable%0d", i), {PSEL, PENABLE, PWRITE, PADDR}, {1'b1, 1'b1, 1'b0, 5'h10});
      if (i == 3) begin
        pready_r = 1'b1; pslverr_r = 1'b1; err_clr = 1'b1; status_r = 8'h04;
      end
    end
    @(posedge PCLK); #1;
    pslverr_r = 1'b0; err_clr = 1'b0; status_r = 8'h00;
    @(negedge PCLK);
    check("bus_err_set", bus_err, 1'b1);
    check("parity_set_wins", {framing_err, overflow, parity_err}, 3'b001);
    check("gap_after_err", PSEL, 1'b0);

    // Reset in TXWR ACCESS, then full reconfiguration.
    status_r = 8'h01; tx_valid = 1'b1; tx_data = 8'h99;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge PCLK);
      if (tx_ready) begin
        @(posedge PCLK); #1;
        tx_valid = 1'b0;
      end else if (PSEL && PENABLE && PWRITE && PADDR == 5'h00) begin
        found = 1'b1;
      end
    end
    check("txwr_found", found, 1'b1);
    check("txwr_data", PWDATA, 8'h99);
    PRESETN = 1'b0;
    #1;
    check("midreset_apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 16'h0);
    check("midreset_misc", {tx_ready, rx_valid, rx_data, cfg_done}, 11'h0);
    check("midreset_flags", {parity_err, framing_err, overflow, bus_err}, 4'h0);
    status_r = 8'h00;
    repeat (2) @(negedge PCLK);
    PRESETN = 1'b1;
    cfg_seq("rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
